uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter. It frames a byte as 8N1, or optionally with a parity bit and 2 stop bits, and drives UART_TXD.
- It is the upstream peer of the existing UART receive controller and uses the same CLKS_PER_BIT bit timing.
- Bytes are accepted through a valid/ready handshake.
- Start of a new frame is gated by an active-low clear-to-send input.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit (50 MHz / 9600 baud); minimum 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- TX_DATA  in  8  byte to send; sampled on handshake.
- TX_VALID  in  1  TX_DATA is valid.
- TX_READY  out  1  block can accept a byte this cycle.
- TX_BUSY  out  1  a frame is in progress.
- TX_DONE  out  1  one-cycle pulse on the last cycle of the final stop bit.
- UART_CTS_N  in  1  asynchronous; low = peer can receive.
- UART_TXD  out  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - UART_TXD=1, TX_READY=0, TX_BUSY=0, TX_DONE=0.
  - state=IDLE; bit counter, bit index and shift register cleared.
  - CTS synchroniser flops set to 1 (not clear).
- CTS synchroniser: UART_CTS_N passes through a 2-flop synchroniser; cts_ok = !synced value.
- Handshake:
  - TX_READY = (state==IDLE) && cts_ok. It is a registered-state function and does not depend on TX_VALID.
  - A byte is accepted when TX_VALID && TX_READY on a rising edge. TX_DATA is latched into the shift register.
  - Parity bit = XOR of the byte, XOR PARITY_ODD.
- States:
  - IDLE: UART_TXD=1. On accept -> START.
  - START: UART_TXD=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, index 0..7. After index 7 completes -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: parity bit held CLKS_PER_BIT cycles -> STOP.
  - STOP: UART_TXD=1 for STOP_BITS*CLKS_PER_BIT cycles. TX_DONE=1 on the final cycle. Then -> IDLE.
  - Illegal encoding -> IDLE with UART_TXD=1.
- Output timing:
  - UART_TXD is driven from a flop (glitch-free).
  - The first start-bit cycle on the line is the cycle after the accept edge.
  - Total frame length = (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, exactly.
- Bit counter: 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- TX_BUSY = (state != IDLE).
- Back-to-back frames:
  - The cycle after TX_DONE, state=IDLE and TX_READY can be 1.
  - Minimum gap between frames = 1 idle-high cycle.
- CTS deasserted mid-frame: the current frame completes unchanged; the next frame waits.
- TX_VALID while busy: ignored, no accept. Upstream must hold TX_DATA until the handshake.
- Reset mid-frame: UART_TXD goes high immediately (asynchronously); the partial byte is discarded, with no TX_DONE.

Decomposition:
- uart_pkg holds:
  - the state encoding (3-bit localparams IDLE, START, DATA, PARITY, STOP);
  - CLKS_PER_BIT_DEFAULT=5208;
  - DATA_BITS=8.
  The receive controller uses the same package.
- One sub-module, uart_baud_counter: bit-period counter with clear and enable inputs and a bit_end pulse output, parameterised by CLKS_PER_BIT. It is reusable by the receiver.

Test Plan (all scenarios use CLKS_PER_BIT=4):
- Reset release, CTS_N=0 held low:
  - TXD=1, READY=0 until CTS has synchronised (2 cycles), then READY=1.
  - BUSY=0, DONE=0 throughout.
- Send 0xA5, 8N1:
  - TXD sequence per 4-cycle slot: 0, then 1,0,1,0,0,1,0,1, then 1.
  - 40 cycles total; DONE pulses on cycle 40; READY returns the next cycle.
- PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2:
  - 0x07 gives parity slot = 1; 0x03 gives parity slot = 0.
  - Frame length = 48 cycles each.
- Back-to-back 0x00 then 0xFF with VALID held high:
  - Second start bit begins exactly 1 cycle after the first DONE.
  - Received pattern matches when looped into the receive controller with the same CLKS_PER_BIT; LEDR = 0xFF at the end.
- CTS_N=1 with VALID=1 and 0x3C presented:
  - READY stays 0 and TXD stays 1.
  - Drive CTS_N=0: frame starts 3 cycles later (2 sync + accept).
  - CTS_N raised mid-DATA: frame still completes.
- Reset asserted during DATA bit 3 of 0x55:
  - TXD=1 and BUSY=0 immediately; no DONE.
  - After release, a new 0x55 frame is transmitted cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and parity helper.
// Imported by both the transmitter and the receive controller.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned IDX_W                = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit. Shared by the transmitter and receiver.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
  localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  assign bit_end = enable && (count == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_end ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, CTS-gated frame start, 8 data bits
// LSB first with optional parity and 1 or 2 stop bits on a registered TXD line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  input  logic       UART_CTS_N,
  output logic       UART_TXD
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic        LAST_STOP = (STOP_BITS > 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   stop_q, stop_d;
  logic                   txd_q, txd_d;
  logic                   cts_s1_q, cts_s2_q;
  logic                   busy_q, done_q;
  logic                   cnt_clear, cnt_en, bit_end;
  logic [CNT_W-1:0]       count;
  logic                   accept;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (count),
    .bit_end (bit_end)
  );

  // CTS synchroniser resets to "peer not ready" so nothing starts before it settles.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= UART_CTS_N;
      cts_s2_q <= cts_s1_q;
    end
  end

  assign TX_READY = (state_q == IDLE) && !cts_s2_q;
  assign accept   = TX_VALID && TX_READY;
  assign TX_BUSY  = busy_q;
  assign TX_DONE  = done_q;
  assign UART_TXD = txd_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      stop_q   <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      stop_q   <= stop_d;
      txd_q    <= txd_d;
      busy_q   <= (state_d != IDLE);
      // Raised one cycle early so the registered pulse lands on the final stop cycle.
      done_q   <= (state_q == STOP) && (stop_q == LAST_STOP) &&
                  (count == CNT_W'(CLKS_PER_BIT - 2));
    end
  end

  // txd_d is the line value for the state being entered, keeping TXD aligned with state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    stop_d    = stop_q;
    txd_d     = txd_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        txd_d     = 1'b1;
        if (accept) begin
          state_d  = START;
          shift_d  = TX_DATA;
          parity_d = parity_bit(TX_DATA, PARITY_ODD);
          idx_d    = '0;
          stop_d   = 1'b0;
          txd_d    = 1'b0;
        end
      end
      START: begin
        cnt_en = 1'b1;
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        end
      end
      DATA: begin
        cnt_en = 1'b1;
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
      PARITY: begin
        cnt_en = 1'b1;
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        txd_d  = 1'b1;
        if (bit_end) begin
          if (stop_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        txd_d     = 1'b1;
        cnt_clear = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (8N1 and even-parity/2-stop) at
// 4 clocks per bit, with line monitors that decode frames against a bit-list model.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int PEN1  = 1;
  localparam int PODD1 = 0;
  localparam int SB0   = 1;
  localparam int SB1   = 2;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] bits;
    int          nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cts_n;
  logic [7:0] data  [2];
  logic       valid [2];
  logic       ready [2];
  logic       busy  [2];
  logic       done  [2];
  logic       txd   [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc  [2];
  int done_cyc [2];
  frame_t q0[$];
  frame_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(SB0)) u_tx0 (
    .CLOCK_50(clk), .RESET_N(rst_n), .TX_DATA(data[0]), .TX_VALID(valid[0]),
    .TX_READY(ready[0]), .TX_BUSY(busy[0]), .TX_DONE(done[0]),
    .UART_CTS_N(cts_n), .UART_TXD(txd[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(SB1)) u_tx1 (
    .CLOCK_50(clk), .RESET_N(rst_n), .TX_DATA(data[1]), .TX_VALID(valid[1]),
    .TX_READY(ready[1]), .TX_BUSY(busy[1]), .TX_DONE(done[1]),
    .UART_CTS_N(cts_n), .UART_TXD(txd[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: list of line levels, one per bit slot, first slot first.
  function automatic frame_t make_frame(input int k, input logic [7:0] b);
    frame_t f;
    int n;
    int ones;
    f.b    = b;
    f.bits = '1;
    f.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      f.bits[n] = b[i];
      n++;
    end
    if (k == 1 && PEN1 == 1) begin
      ones = $countones(b);
      f.bits[n] = 1'(((ones % 2) + PODD1) % 2);
      n++;
    end
    n += (k == 1) ? SB1 : SB0;
    f.nbits = n;
    return f;
  endfunction

  task automatic send(input int k, input logic [7:0] b, input bit hold);
    int n;
    bit ok;
    data[k]  = b;
    valid[k] = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 400) begin
      @(negedge clk);
      if (ready[k] === 1'b1) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      check($sformatf("tx%0d_accept_timeout", k), 1, 0);
      valid[k] = 1'b0;
    end else begin
      @(posedge clk);
      if (k == 0) q0.push_back(make_frame(0, b));
      else        q1.push_back(make_frame(1, b));
      #1;
      acc_cyc[k] = cyc;
      if (!hold) valid[k] = 1'b0;
    end
  endtask

  task automatic wait_done(input int k, output int dc);
    bit seen;
    seen = 1'b0;
    dc   = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done[k] === 1'b1) begin
        seen = 1'b1;
        dc   = cyc;
      end
    end
    if (!seen) check($sformatf("tx%0d_done_timeout", k), 1, 0);
  endtask

  task automatic frame_len(input int k, input logic [7:0] b, input int exp_cycles);
    int dc;
    send(k, b, 1'b0);
    wait_done(k, dc);
    check($sformatf("tx%0d_len_%02h", k, b), 32'(dc - acc_cyc[k] + 1), 32'(exp_cycles));
  endtask

  // Line monitor: detects a start bit, pops the expected frame and checks every cycle.
  task automatic monitor(input int k);
    frame_t f;
    int     len, mism, dbad, n;
    bit     abort, empty;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && txd[k] === 1'b0) begin
        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          check($sformatf("tx%0d_unexpected_frame", k), 1, 0);
          n = 0;
          while (busy[k] === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
          end
        end else begin
          f     = (k == 0) ? q0.pop_front() : q1.pop_front();
          len   = f.nbits * CPB;
          mism  = 0;
          dbad  = 0;
          abort = 1'b0;
          for (int c = 0; c < len && !abort; c++) begin
            if (c > 0) begin
              @(posedge clk); #1;
            end
            if (rst_n !== 1'b1) begin
              abort = 1'b1;
            end else begin
              if (txd[k] !== f.bits[c / CPB]) mism++;
              if (busy[k] !== 1'b1) mism++;
              if (done[k] !== (c == len - 1)) dbad++;
            end
          end
          if (!abort) begin
            check($sformatf("tx%0d_line_%02h", k, f.b), 32'(mism), 0);
            check($sformatf("tx%0d_done_%02h", k, f.b), 32'(dbad), 0);
            done_cyc[k] = cyc;
          end
        end
      end else begin
        check($sformatf("tx%0d_idle_done", k), 32'(done[k]), 0);
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    int p;
    int n;
    rst_n    = 1'b0;
    cts_n    = 1'b0;
    valid[0] = 1'b0; valid[1] = 1'b0;
    data[0]  = '0;   data[1]  = '0;
    acc_cyc[0] = 0;  acc_cyc[1] = 0;
    done_cyc[0] = 0; done_cyc[1] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd0", 32'(txd[0]), 1);
    check("rst_txd1", 32'(txd[1]), 1);
    check("rst_ready", 32'(ready[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_sync1", 32'(ready[0]), 0);
    @(posedge clk); #1;
    check("ready_sync2", 32'(ready[0]), 1);
    check("ready_sync2_p", 32'(ready[1]), 1);
    check("idle_busy", 32'(busy[0]), 0);

    // 8N1 frame of 0xA5, then ready returns right after DONE
    frame_len(0, 8'hA5, 40);
    @(posedge clk); #1;
    check("post_done_ready", 32'(ready[0]), 1);
    check("post_done_busy", 32'(busy[0]), 0);
    check("post_done_txd", 32'(txd[0]), 1);

    // Even parity, two stop bits
    frame_len(1, 8'h07, 48);
    frame_len(1, 8'h03, 48);

    // Back-to-back with VALID held high: one idle cycle between frames
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b0);
    check("b2b_gap", 32'(acc_cyc[0] - done_cyc[0]), 2);
    wait_done(0, p);

    // CTS held off blocks the start
    @(posedge clk); #1;
    cts_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    data[0]  = 8'h3C;
    valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("cts_hold_ready", 32'(ready[0]), 0);
      check("cts_hold_txd", 32'(txd[0]), 1);
    end
    cts_n = 1'b0;
    p = cyc;
    send(0, 8'h3C, 1'b0);
    check("cts_start_delay", 32'(acc_cyc[0] - p), 3);
    repeat (10) @(posedge clk);
    #1;
    cts_n = 1'b1;
    wait_done(0, n);
    check("cts_len", 32'(n - acc_cyc[0] + 1), 40);
    @(posedge clk); #1;
    check("cts_off_ready", 32'(ready[0]), 0);
    cts_n = 1'b0;

    // Reset during data bit 3 of 0x55
    send(0, 8'h55, 1'b0);
    repeat (18) @(posedge clk);
    @(negedge clk);
    check("bit3_txd", 32'(txd[0]), 0);
    check("bit3_busy", 32'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd[0]), 1);
    check("midrst_busy", 32'(busy[0]), 0);
    check("midrst_done", 32'(done[0]), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    frame_len(0, 8'h55, 40);

    // Randomised traffic on both instances
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #1;
          send(0, 8'($urandom), (i < 14) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
      end
      begin
        for (int i = 0; i < 15; i++) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #1;
          send(1, 8'($urandom), (i < 14) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
      end
    join

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy[0] === 1'b1 || busy[1] === 1'b1) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
    check("end_busy0", 32'(busy[0]), 0);
    check("end_busy1", 32'(busy[1]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
